swd_target: RTL
===============

Name: swd_target

Overview:
- Synthesisable SW-DP target (responder) for the SWD link. It is the far end of the host-side SWD initiator.
- Oversamples the host's swclk/swdio in the system clock domain and decodes 8-bit requests.
- Drives ACK, read data and parity, and captures write data and parity.
- Used as a loopback target for orbtrace host-interface benches and as a DP emulation front-end; a register file attaches via strobes.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for swclk_in and swdio_in; both use identical depth so samples stay aligned.
- LINE_RESET_BITS, 50, consecutive sampled 1s that constitute a line reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low (0 = reset)
- swclk_in  in  1  SWCLK from host, asynchronous to clk
- swdio_in  in  1  SWDIO pin value
- swdio_out  out  1  SWDIO value driven by target
- swdio_oe  out  1  1 = target drives SWDIO
- req_stb  out  1  one-clk pulse: a valid request has been decoded
- req_apndp  out  1  APnDP of last request
- req_rnw  out  1  RnW of last request
- req_addr  out  2  A[3:2] of last request
- ack_resp  in  3  ACK to return: 001 OK, 010 WAIT, 100 FAULT, 111 no response
- rdata  in  32  read data returned on OK reads
- rd_stb  out  1  one-clk pulse: read data and parity fully shifted out
- wr_stb  out  1  one-clk pulse: wdata valid, parity good
- wdata  out  32  captured write data
- par_err  out  1  one-clk pulse: request or write-data parity error
- line_reset  out  1  one-clk pulse: line reset detected

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs are 0, wdata is 0, and req_* are 0.
  - State is IDLE, the line-reset count is 0, and the synchroniser history is cleared.
  - Reset mid-transaction releases SWDIO on the next clk.
- Edge detection:
  - A rising edge is sync swclk=1 while the previous sync value was 0.
  - All sampling uses sync swdio at that clk.
  - swdio_out and swdio_oe are registered and change 1 clk after the detected edge.
  - Minimum supported swclk half-period is SYNC_STAGES+3 clk.
- Edge numbering: rising edges within a transaction are numbered from E0 = the start bit.
- States: IDLE, REQ, TRN1, ACK, RDATA, TRN2, WDATA, LR_WAIT.
- IDLE: sampled 1 is the start bit, go to REQ. Sampled 0 stays in IDLE.
- REQ (E1..E7), bits in order APnDP, RnW, A2, A3, parity, stop, park:
  - Request is valid when parity = XOR(APnDP,RnW,A2,A3), stop=0 and park=1.
  - Valid: latch req_* and pulse req_stb at E7, then go to TRN1.
  - Parity bad: pulse par_err, go to IDLE, never drive.
  - Stop/park bad: go to IDLE with no pulse.
- TRN1 (E8): no drive.
  - ack_resp and rdata are captured at E8.
  - If the captured ack is 111, go to IDLE with oe=0.
- ACK (E9..E11): oe=1 and drive ack bit0, bit1, bit2.
  - OK+read: go to RDATA.
  - OK+write: go to TRN2.
  - WAIT or FAULT: go to TRN2, then IDLE.
- RDATA:
  - E12..E43 drive rdata[0..31]; E44 drives even parity (XOR of all 32 bits).
  - E45 sets oe=0 and pulses rd_stb, then go to IDLE.
- TRN2 (E12): oe=0.
  - Write OK: go to WDATA.
  - Otherwise: go to IDLE.
- WDATA:
  - E13..E44 sample bits 0..31 into a shift register.
  - E45 samples parity.
  - Parity match: update wdata and pulse wr_stb.
  - Mismatch: pulse par_err and leave wdata unchanged.
  - Then go to IDLE.
- Line reset:
  - Counter of consecutive sampled 1s, counted only on edges where oe=0; saturates at LINE_RESET_BITS.
  - Any sampled 0 clears it.
  - On reaching LINE_RESET_BITS: from any state abort, oe=0, pulse line_reset once, go to LR_WAIT.
  - LR_WAIT exits to IDLE on the first sampled 0; no start bit is accepted before that 0.
- Simultaneous events: the line_reset pulse takes precedence over par_err; both never pulse in the same clk.
- swclk stopped mid-transaction: state holds indefinitely; there is no timeout.

Test Plan:
1. OK read:
   - Stimulus: request bits 1,1,1,1,0,1,0,1 (AP, read, A=01); ack_resp=001; rdata=0xabcdef12.
   - Response: req_stb with apndp=1, rnw=1, addr=01; host samples ACK 1,0,0; then 0x12,0xef,0xcd,0xab LSB-first; parity 1; rd_stb pulse; oe=0 at E45.
2. OK write:
   - Stimulus: request 1,0,0,0,1,1,0,1 (DP, write, A=10); ack_resp=001; host sends 0x12345678 with parity 1.
   - Response: wr_stb pulse, wdata=0x12345678, par_err=0.
3. Write parity error: same as scenario 2 but parity 0 -> par_err pulse, no wr_stb, wdata retains its prior value.
4. Request parity error and non-response:
   - Request parity bit flipped -> par_err, swdio_oe stays 0 throughout.
   - ack_resp=111 -> no drive, IDLE.
   - ack_resp=010 -> ACK 0,1,0, then oe=0, no data phase.
5. Line reset:
   - 60 ones mid-RDATA with oe=0 (abort) or from IDLE -> single line_reset pulse.
   - Next request is ignored until a 0 is seen; after one 0, an OK read succeeds.
6. Reset:
   - rst=0 during ACK drive -> oe=0 next clk, all outputs 0.
   - After release, a fresh read completes normally.
   - Rerun scenario 1 with swclk half-period = SYNC_STAGES+3 clk -> identical result.

Source files
------------

// File: rtl/swd_target.sv
// SW-DP responder: oversamples swclk/swdio, decodes requests, returns ACK/read data, captures write data.
// Line outputs are registered one clk after each detected swclk rise; no backpressure, the host clock paces everything.
module swd_target #(
    parameter int SYNC_STAGES     = 2,
    parameter int LINE_RESET_BITS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swclk_in,
    input  logic        swdio_in,
    output logic        swdio_out,
    output logic        swdio_oe,
    output logic        req_stb,
    output logic        req_apndp,
    output logic        req_rnw,
    output logic [1:0]  req_addr,
    input  logic [2:0]  ack_resp,
    input  logic [31:0] rdata,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic [31:0] wdata,
    output logic        par_err,
    output logic        line_reset
);
    localparam int LRW = $clog2(LINE_RESET_BITS + 1);
    localparam logic [LRW-1:0] LR_MAX  = LRW'(LINE_RESET_BITS);
    localparam logic [LRW-1:0] LR_LAST = LRW'(LINE_RESET_BITS - 1);
    localparam logic [2:0]     ACK_OK   = 3'b001;
    localparam logic [2:0]     ACK_NONE = 3'b111;

    typedef enum logic [2:0] {
        IDLE, REQ, TRN1, ACK, RDATA, TRN2, WDATA, LR_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dio_sync;
    logic                   clk_prev;
    logic                   sclk;
    logic                   sdio;
    logic                   rise;
    logic                   lr_hit;

    state_t         state;
    logic [5:0]     bit_cnt;
    logic [5:0]     req_sr;
    logic [2:0]     ack_q;
    logic           ack_ok;
    logic [31:0]    rd_q;
    logic [31:0]    wr_sr;
    logic [LRW-1:0] lr_cnt;

    assign sclk = clk_sync[SYNC_STAGES-1];
    assign sdio = dio_sync[SYNC_STAGES-1];
    assign rise = sclk & ~clk_prev;

    // Only line cycles the target is not driving can contribute to a line reset.
    assign lr_hit = rise & sdio & ~swdio_oe & (lr_cnt == LR_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync <= '0;
            dio_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], swclk_in};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], swdio_in};
            clk_prev <= sclk;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            req_sr     <= '0;
            ack_q      <= '0;
            ack_ok     <= 1'b0;
            rd_q       <= '0;
            wr_sr      <= '0;
            lr_cnt     <= '0;
            swdio_out  <= 1'b0;
            swdio_oe   <= 1'b0;
            req_stb    <= 1'b0;
            req_apndp  <= 1'b0;
            req_rnw    <= 1'b0;
            req_addr   <= '0;
            rd_stb     <= 1'b0;
            wr_stb     <= 1'b0;
            wdata      <= '0;
            par_err    <= 1'b0;
            line_reset <= 1'b0;
        end else begin
            req_stb    <= 1'b0;
            rd_stb     <= 1'b0;
            wr_stb     <= 1'b0;
            par_err    <= 1'b0;
            line_reset <= 1'b0;

            if (rise) begin
                if (!sdio)
                    lr_cnt <= '0;
                else if (!swdio_oe && lr_cnt != LR_MAX)
                    lr_cnt <= lr_cnt + 1'b1;

                if (lr_hit) begin
                    state      <= LR_WAIT;
                    swdio_oe   <= 1'b0;
                    swdio_out  <= 1'b0;
                    line_reset <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (sdio) begin
                                state   <= REQ;
                                bit_cnt <= '0;
                            end
                        end
                        REQ: begin
                            // After six shifts req_sr[0] holds APnDP and req_sr[5] the stop bit.
                            req_sr  <= {sdio, req_sr[5:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 6'd6) begin
                                if (req_sr[4] != ^req_sr[3:0]) begin
                                    par_err <= 1'b1;
                                    state   <= IDLE;
                                end else if (!req_sr[5] && sdio) begin
                                    req_apndp <= req_sr[0];
                                    req_rnw   <= req_sr[1];
                                    req_addr  <= {req_sr[3], req_sr[2]};
                                    req_stb   <= 1'b1;
                                    state     <= TRN1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                        TRN1: begin
                            ack_q   <= ack_resp;
                            ack_ok  <= (ack_resp == ACK_OK);
                            rd_q    <= rdata;
                            bit_cnt <= '0;
                            state   <= (ack_resp == ACK_NONE) ? IDLE : ACK;
                        end
                        ACK: begin
                            swdio_oe  <= 1'b1;
                            swdio_out <= ack_q[0];
                            ack_q     <= {1'b0, ack_q[2:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == 6'd2) begin
                                bit_cnt <= '0;
                                state   <= (ack_ok && req_rnw) ? RDATA : TRN2;
                            end
                        end
                        RDATA: begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 6'd32) begin
                                swdio_out <= rd_q[bit_cnt[4:0]];
                            end else if (bit_cnt == 6'd32) begin
                                swdio_out <= ^rd_q;
                            end else begin
                                swdio_oe  <= 1'b0;
                                swdio_out <= 1'b0;
                                rd_stb    <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                        TRN2: begin
                            swdio_oe  <= 1'b0;
                            swdio_out <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= (ack_ok && !req_rnw) ? WDATA : IDLE;
                        end
                        WDATA: begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 6'd32) begin
                                wr_sr <= {sdio, wr_sr[31:1]};
                            end else begin
                                if (sdio == ^wr_sr) begin
                                    wdata  <= wr_sr;
                                    wr_stb <= 1'b1;
                                end else begin
                                    par_err <= 1'b1;
                                end
                                state <= IDLE;
                            end
                        end
                        LR_WAIT: begin
                            if (!sdio)
                                state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
